// File: rtl/adc_iq_downconverter.sv
`default_nettype none
// ============================================================================
// Module   : adc_iq_downconverter
// Brief    : Mixes offset-binary ADC samples with an NCO sin/cos LO and
//            integrates-and-dumps the I/Q products over DUMP_LEN samples.
// Revision : 1.0 - initial release
// ============================================================================
module adc_iq_downconverter #(
  parameter int DUMP_LEN = 64,
  parameter int ACC_W    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [5:0]       adc_sample,
  input  logic [4:0]       lo_sin,
  input  logic [4:0]       lo_cos,
  input  logic             sync,
  output logic [ACC_W-1:0] dump_i,
  output logic [ACC_W-1:0] dump_q,
  output logic             dump_clip,
  output logic             dump_valid
);

  localparam int              CNT_W  = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DUMP_LEN - 1);

  // ---------------------------------------------------------------- stage 1
  logic signed [6:0]  w_s;
  logic               w_clip;

  logic signed [6:0]  r_s;
  logic signed [4:0]  r_sin;
  logic signed [4:0]  r_cos;
  logic               r_clip1;
  logic               r_v1;

  assign w_s    = $signed({1'b0, adc_sample}) - 7'sd32;
  assign w_clip = (adc_sample == 6'd0) || (adc_sample == 6'd63);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= '0;
      r_sin   <= '0;
      r_cos   <= '0;
      r_clip1 <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      // A sample accepted on a sync edge is dropped via its valid bit.
      r_v1 <= clk_en & ~sync;
      if (clk_en) begin
        r_s     <= w_s;
        r_sin   <= $signed(lo_sin);
        r_cos   <= $signed(lo_cos);
        r_clip1 <= w_clip;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [10:0] w_s_x;
  logic signed [10:0] w_sin_x;
  logic signed [10:0] w_cos_x;
  logic signed [10:0] w_pi;
  logic signed [10:0] w_pq;

  logic signed [10:0] r_pi;
  logic signed [10:0] r_pq;
  logic               r_clip2;
  logic               r_v2;

  // Products span -512..512 at most, so 11-bit modular arithmetic is exact.
  assign w_s_x   = {{4{r_s[6]}}, r_s};
  assign w_sin_x = {{6{r_sin[4]}}, r_sin};
  assign w_cos_x = {{6{r_cos[4]}}, r_cos};
  assign w_pi    = w_s_x * w_cos_x;
  assign w_pq    = -(w_s_x * w_sin_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pi    <= '0;
      r_pq    <= '0;
      r_clip2 <= 1'b0;
      r_v2    <= 1'b0;
    end else begin
      r_v2 <= r_v1 & ~sync;
      if (r_v1) begin
        r_pi    <= w_pi;
        r_pq    <= w_pq;
        r_clip2 <= r_clip1;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic signed [ACC_W-1:0] w_pi_ext;
  logic signed [ACC_W-1:0] w_pq_ext;
  logic signed [ACC_W-1:0] w_sum_i;
  logic signed [ACC_W-1:0] w_sum_q;
  logic                    w_last;

  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;
  logic                    r_clip_acc;
  logic [CNT_W-1:0]        r_win_cnt;
  logic [ACC_W-1:0]        r_dump_i;
  logic [ACC_W-1:0]        r_dump_q;
  logic                    r_dump_clip;
  logic                    r_dump_valid;

  assign w_pi_ext = {{(ACC_W-11){r_pi[10]}}, r_pi};
  assign w_pq_ext = {{(ACC_W-11){r_pq[10]}}, r_pq};
  assign w_sum_i  = r_acc_i + w_pi_ext;
  assign w_sum_q  = r_acc_q + w_pq_ext;
  assign w_last   = (r_win_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_i      <= '0;
      r_acc_q      <= '0;
      r_clip_acc   <= 1'b0;
      r_win_cnt    <= '0;
      r_dump_i     <= '0;
      r_dump_q     <= '0;
      r_dump_clip  <= 1'b0;
      r_dump_valid <= 1'b0;
    end else if (sync) begin
      // sync wins over a coincident dump; dump_* keep their old values.
      r_acc_i      <= '0;
      r_acc_q      <= '0;
      r_clip_acc   <= 1'b0;
      r_win_cnt    <= '0;
      r_dump_valid <= 1'b0;
    end else if (r_v2) begin
      if (w_last) begin
        r_dump_i     <= w_sum_i;
        r_dump_q     <= w_sum_q;
        r_dump_clip  <= r_clip_acc | r_clip2;
        r_dump_valid <= 1'b1;
        r_acc_i      <= '0;
        r_acc_q      <= '0;
        r_clip_acc   <= 1'b0;
        r_win_cnt    <= '0;
      end else begin
        r_acc_i      <= w_sum_i;
        r_acc_q      <= w_sum_q;
        r_clip_acc   <= r_clip_acc | r_clip2;
        r_win_cnt    <= r_win_cnt + CNT_W'(1);
        r_dump_valid <= 1'b0;
      end
    end else begin
      r_dump_valid <= 1'b0;
    end
  end

  assign dump_i     = r_dump_i;
  assign dump_q     = r_dump_q;
  assign dump_clip  = r_dump_clip;
  assign dump_valid = r_dump_valid;

endmodule
`default_nettype wire

// File: tb/tb_adc_iq_downconverter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_iq_downconverter
// Brief    : Directed self-checking bench for adc_iq_downconverter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_iq_downconverter;

  localparam int DUMP_LEN = 64;
  localparam int ACC_W    = 24;
  localparam int C_LIMIT  = 600;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clk_en = 1'b0;
  logic [5:0]       adc_sample = 6'd32;
  logic [4:0]       lo_sin = 5'd0;
  logic [4:0]       lo_cos = 5'd0;
  logic             sync = 1'b0;
  logic [ACC_W-1:0] dump_i;
  logic [ACC_W-1:0] dump_q;
  logic             dump_clip;
  logic             dump_valid;

  int  checks = 0;
  int  errors = 0;
  bit  strobe_mode = 1'b0;
  int  n;

  adc_iq_downconverter #(.DUMP_LEN(DUMP_LEN), .ACC_W(ACC_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .adc_sample (adc_sample),
    .lo_sin     (lo_sin),
    .lo_cos     (lo_cos),
    .sync       (sync),
    .dump_i     (dump_i),
    .dump_q     (dump_q),
    .dump_clip  (dump_clip),
    .dump_valid (dump_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (strobe_mode) clk_en = ~clk_en;
  endtask

  // Counts edges until dump_valid is seen (bounded).
  task automatic wait_dump(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!dump_valid && cnt < C_LIMIT);
    if (!dump_valid) check("dump_timeout", 32'(dump_valid), 1);
  endtask

  task automatic set_lo(input logic [5:0] a, input logic [4:0] c,
                        input logic [4:0] s);
    adc_sample = a;
    lo_cos     = c;
    lo_sin     = s;
  endtask

  task automatic check_dump(input string tag, input int ei, input int eq,
                            input int ec);
    check({tag, "_i"},    $signed(dump_i), ei);
    check({tag, "_q"},    $signed(dump_q), eq);
    check({tag, "_clip"}, 32'(dump_clip), ec);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_dump("rst0", 0, 0, 0);
    check("rst0_valid", 32'(dump_valid), 0);

    // Positive full scale from reset release: s=31, cos=15 -> 465*64
    set_lo(6'd63, 5'd15, 5'd0);
    clk_en = 1'b1;
    rst    = 1'b0;
    wait_dump(n);
    check("first_latency", n, DUMP_LEN + 2);
    check_dump("pfs", 29760, 0, 1);
    tick();
    check("valid_one_cycle", 32'(dump_valid), 0);
    wait_dump(n);
    check("period_cont", n, DUMP_LEN - 1);
    check_dump("pfs2", 29760, 0, 1);

    // Asynchronous reset mid-window
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    check_dump("rst_mid", 0, 0, 0);
    check("rst_mid_valid", 32'(dump_valid), 0);
    tick();
    rst = 1'b0;
    wait_dump(n);
    check("rst_latency", n, DUMP_LEN + 2);
    check_dump("rst_pfs", 29760, 0, 1);

    // DC zero
    set_lo(6'd32, 5'd9, 5'd27);
    wait_dump(n);
    wait_dump(n);
    check("dc_period", n, DUMP_LEN);
    check_dump("dc", 0, 0, 0);

    // Negative extremes: s=-32, cos=sin=-16 -> +/-512*64
    set_lo(6'd0, 5'h10, 5'h10);
    wait_dump(n);
    wait_dump(n);
    check_dump("neg", 32768, -32768, 1);

    // Strobed input with positive full scale
    set_lo(6'd63, 5'd15, 5'd0);
    strobe_mode = 1'b1;
    wait_dump(n);
    wait_dump(n);
    check("strobe_period", n, 2 * DUMP_LEN);
    check_dump("strobe", 29760, 0, 1);
    strobe_mode = 1'b0;
    clk_en = 1'b1;

    // sync after ~10 samples of negative data; only post-sync samples count
    set_lo(6'd0, 5'h10, 5'h10);
    wait_dump(n);
    wait_dump(n);
    repeat (10) tick();
    set_lo(6'd63, 5'd15, 5'd0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    wait_dump(n);
    check("sync_latency", n, DUMP_LEN + 2);
    check_dump("sync_win", 29760, 0, 1);

    // sync on the exact dump edge
    wait_dump(n);
    repeat (DUMP_LEN - 1) tick();
    check("pre_sync_valid", 32'(dump_valid), 0);
    set_lo(6'd32, 5'd3, 5'd5);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_dump_valid", 32'(dump_valid), 0);
    check_dump("sync_hold", 29760, 0, 1);
    wait_dump(n);
    check("sync_dump_latency", n, DUMP_LEN + 2);
    check_dump("sync_dc", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
